food_placer: RTL and testbench



---
 rtl/food_placer.sv | 241 ++++++++++++++++++++++++
 tb/tb_food_placer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_placer.sv
`timescale 1ns/1ps
// food_placer: draws random column/row candidates from the 7-bit stream,
// rejects values outside the grid, checks each candidate against the snake
// body through an occupancy query handshake, and publishes the food cell.
// Optional macro FOOD_FALLBACK_SCAN_EN adds a linear scan after MAX_TRIES
// occupied hits and reports grid_full when every cell is taken.
module food_placer #(
  parameter int GRID_COLS  = 40,
  parameter int GRID_ROWS  = 30,
  parameter int SAMPLE_GAP = 7,
  parameter int INIT_X     = 20,
  parameter int INIT_Y     = 15,
  parameter int MAX_TRIES  = 16
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       place_req,
  input  logic [6:0] rnd,
  output logic       occ_req,
  output logic [5:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [5:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       done,
  output logic       busy,
  output logic       grid_full
);

  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_X = 3'd1,
    WAIT_Y = 3'd2,
`ifdef FOOD_FALLBACK_SCAN_EN
    QUERY  = 3'd3,
    SCAN   = 3'd4
`else
    QUERY  = 3'd3
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TRY_W-1:0]   try_q, try_d, try_inc;
  logic [5:0]         cand_x_q, cand_x_d;
  logic               occ_req_q, occ_req_d;
  logic [5:0]         occ_x_q, occ_x_d;
  logic [4:0]         occ_y_q, occ_y_d;
  logic [5:0]         food_x_q, food_x_d;
  logic [4:0]         food_y_q, food_y_d;
  logic               food_valid_q, food_valid_d;
  logic               done_q, done_d;

`ifdef FOOD_FALLBACK_SCAN_EN
  localparam int SCAN_W = $clog2(GRID_COLS * GRID_ROWS + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(GRID_COLS * GRID_ROWS - 1);

  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic               grid_full_q, grid_full_d;
  logic [5:0]         adv_x;
  logic [4:0]         adv_y;

  // Next cell in row-major scan order after the current query cell, with wrap.
  always_comb begin
    adv_x = occ_x_q + 6'd1;
    adv_y = occ_y_q;
    if (occ_x_q == 6'(GRID_COLS - 1)) begin
      adv_x = 6'd0;
      adv_y = (occ_y_q == 5'(GRID_ROWS - 1)) ? 5'd0 : occ_y_q + 5'd1;
    end
  end
`endif

  // Next-state and output logic for the draw / query sequencer.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    try_d        = try_q;
    cand_x_d     = cand_x_q;
    occ_req_d    = occ_req_q;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    done_d       = 1'b0;
    try_inc      = (try_q == TRY_MAX) ? try_q : try_q + 1'b1;
`ifdef FOOD_FALLBACK_SCAN_EN
    scan_d       = scan_q;
    grid_full_d  = grid_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (place_req) begin
          food_valid_d = 1'b0;
          try_d        = '0;
          gap_d        = '0;
          state_d      = WAIT_X;
`ifdef FOOD_FALLBACK_SCAN_EN
          grid_full_d  = 1'b0;
`endif
        end
      end
      WAIT_X: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (rnd < 7'(GRID_COLS)) begin
            cand_x_d = rnd[5:0];
            state_d  = WAIT_Y;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      WAIT_Y: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (rnd < 7'(GRID_ROWS)) begin
            occ_x_d   = cand_x_q;
            occ_y_d   = rnd[4:0];
            occ_req_d = 1'b1;
            state_d   = QUERY;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      QUERY: begin
        if (occ_ack) begin
          occ_req_d = 1'b0;
          if (!occ_hit) begin
            food_x_d     = occ_x_q;
            food_y_d     = occ_y_q;
            food_valid_d = 1'b1;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else begin
            try_d   = try_inc;
            gap_d   = '0;
            state_d = WAIT_X;
`ifdef FOOD_FALLBACK_SCAN_EN
            if (try_inc == TRY_MAX) begin
              occ_x_d = adv_x;
              occ_y_d = adv_y;
              scan_d  = '0;
              state_d = SCAN;
            end
`endif
          end
        end
      end
`ifdef FOOD_FALLBACK_SCAN_EN
      SCAN: begin
        // occ_req is low for one cycle between cells so each cell gets its own handshake
        if (!occ_req_q) begin
          occ_req_d = 1'b1;
        end else if (occ_ack) begin
          occ_req_d = 1'b0;
          if (!occ_hit) begin
            food_x_d     = occ_x_q;
            food_y_d     = occ_y_q;
            food_valid_d = 1'b1;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else if (scan_q == SCAN_LAST) begin
            grid_full_d = 1'b1;
            state_d     = IDLE;
          end else begin
            occ_x_d = adv_x;
            occ_y_d = adv_y;
            scan_d  = scan_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any draw or query in progress.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      try_q        <= '0;
      cand_x_q     <= '0;
      occ_req_q    <= 1'b0;
      occ_x_q      <= '0;
      occ_y_q      <= '0;
      food_x_q     <= 6'(INIT_X);
      food_y_q     <= 5'(INIT_Y);
      food_valid_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      try_q        <= try_d;
      cand_x_q     <= cand_x_d;
      occ_req_q    <= occ_req_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      done_q       <= done_d;
    end
  end

`ifdef FOOD_FALLBACK_SCAN_EN
  // Scan progress and grid-full flag registers.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      scan_q      <= '0;
      grid_full_q <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      grid_full_q <= grid_full_d;
    end
  end
  assign grid_full = grid_full_q;
`else
  assign grid_full = 1'b0;
`endif

  assign occ_req    = occ_req_q;
  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_food_placer.sv
`timescale 1ns/1ps
// Bench for food_placer: reset values, a table of directed draw sequences,
// hand-written multi-cycle cases, and randomized placements checked against
// a sample-time model of the draw/query rules.
module tb_food_placer;

  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int GAP  = 7;
  localparam int MAXC = 2048;
  localparam int MAXQ = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       place_req;
  logic [6:0] rnd;
  logic       occ_req;
  logic [5:0] occ_x;
  logic [4:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic       food_valid;
  logic       done;
  logic       busy;
  logic       grid_full;

  food_placer dut (
    .clock_25  (clk),
    .reset     (rst_n),
    .place_req (place_req),
    .rnd       (rnd),
    .occ_req   (occ_req),
    .occ_x     (occ_x),
    .occ_y     (occ_y),
    .occ_ack   (occ_ack),
    .occ_hit   (occ_hit),
    .food_x    (food_x),
    .food_y    (food_y),
    .food_valid(food_valid),
    .done      (done),
    .busy      (busy),
    .grid_full (grid_full)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus environment: rnd per cycle after the request edge, body map, ack delays.
  logic [6:0] seq_mem [0:MAXC-1];
  bit         occ_map [0:63][0:31];
  int         dly     [0:MAXQ-1];
  int         exp_qx  [0:MAXQ-1];
  int         exp_qy  [0:MAXQ-1];
  int         obs_qx  [0:MAXQ-1];
  int         obs_qy  [0:MAXQ-1];
  int         obs_done, obs_fx, obs_fy, obs_nq, obs_ndone;
  int         busy_err, valid_err, stab_err;

  typedef struct {
    int s0; int s1; int s2; int s3;   // rnd held in successive 7-cycle windows
    int ex; int ey; int et;           // expected food cell and done cycle
  } vec_t;
  vec_t vecs [0:6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int seq_at(input int k);
    if (k >= 0 && k < MAXC) return int'(seq_mem[k]);
    return 0;
  endfunction

  // Reference: walk sample instants (every GAP cycles from each restart),
  // skip out-of-range draws, a query costs its ack delay plus one cycle.
  task automatic model_run(output int et, output int ex, output int ey, output int enq);
    int t, v, x, y;
    t = 0; et = -1; ex = 0; ey = 0; enq = 0;
    for (int q = 0; q < MAXQ; q++) begin
      do begin t += GAP; v = seq_at(t - 1); end while (v >= COLS);
      x = v;
      do begin t += GAP; v = seq_at(t - 1); end while (v >= ROWS);
      y = v;
      exp_qx[q] = x; exp_qy[q] = y; enq = q + 1;
      t = t + dly[q] + 1;
      if (!occ_map[x][y]) begin
        et = t; ex = x; ey = y;
        break;
      end
    end
  endtask

  // Issue one request and act as the occupancy responder until done (+3 cycles)
  // or the budget expires. Interval k is the cycle after request edge k.
  task automatic run_txn(input int pulse_at, input int budget);
    int  qi, wcnt, d;
    bit  in_q;
    obs_done = -1; obs_fx = -1; obs_fy = -1; obs_nq = 0; obs_ndone = 0;
    busy_err = 0; valid_err = 0; stab_err = 0;
    qi = 0; wcnt = 0; in_q = 0;
    place_req = 1'b1;
    tick();
    place_req = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1) begin
        obs_ndone++;
        if (obs_done < 0) begin
          obs_done = k; obs_fx = int'(food_x); obs_fy = int'(food_y);
        end
      end
      if (obs_done < 0) begin
        if (busy !== 1'b1) busy_err++;
        if (food_valid !== 1'b0) valid_err++;
      end else begin
        if (busy !== 1'b0) busy_err++;
        if (food_valid !== 1'b1) valid_err++;
      end
      occ_ack = 1'b0;
      occ_hit = 1'($urandom);
      if (occ_req === 1'b1) begin
        if (!in_q) begin
          in_q = 1'b1; wcnt = 0; qi = obs_nq;
          if (qi < MAXQ) begin obs_qx[qi] = int'(occ_x); obs_qy[qi] = int'(occ_y); end
          obs_nq++;
        end else if (qi < MAXQ && (int'(occ_x) != obs_qx[qi] || int'(occ_y) != obs_qy[qi])) begin
          stab_err++;
        end
        d = (qi < MAXQ) ? dly[qi] : 0;
        if (wcnt == d) begin
          occ_ack = 1'b1;
          occ_hit = occ_map[occ_x][occ_y];
        end
        wcnt++;
      end else begin
        in_q = 1'b0;
      end
      rnd = seq_at(k);
      place_req = (k == pulse_at);
      if (obs_done >= 0 && k >= obs_done + 3) break;
      tick();
    end
    occ_ack = 1'b0;
    place_req = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int ex, input int ey, input int et, input int enq);
    int qbad;
    qbad = 0;
    for (int i = 0; i < enq && i < obs_nq && i < MAXQ; i++)
      if (obs_qx[i] != exp_qx[i] || obs_qy[i] != exp_qy[i]) qbad++;
    check({tag, " done_cycle"}, obs_done, et);
    check({tag, " food_x"}, obs_fx, ex);
    check({tag, " food_y"}, obs_fy, ey);
    check({tag, " done_pulses"}, obs_ndone, 1);
    check({tag, " query_count"}, obs_nq, enq);
    check({tag, " query_cells"}, qbad, 0);
    check({tag, " busy_profile"}, busy_err, 0);
    check({tag, " valid_profile"}, valid_err, 0);
    check({tag, " occ_stable"}, stab_err, 0);
    $display("txn %s: food=(%0d,%0d) done@%0d queries=%0d", tag, obs_fx, obs_fy, obs_done, obs_nq);
  endtask

  task automatic clear_env();
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++) occ_map[x][y] = 1'b0;
    for (int i = 0; i < MAXQ; i++) dly[i] = 0;
  endtask

  initial begin
    int et, ex, ey, enq, w, v, ph;
    rst_n = 1'b0; place_req = 1'b0; rnd = '0; occ_ack = 1'b0; occ_hit = 1'b0;
    vecs[0] = '{12, 7, 7, 7, 12, 7, 15};
    vecs[1] = '{100, 5, 3, 3, 5, 3, 22};
    vecs[2] = '{5, 30, 3, 3, 5, 3, 22};
    vecs[3] = '{40, 39, 29, 29, 39, 29, 22};
    vecs[4] = '{64, 0, 32, 29, 0, 29, 29};
    vecs[5] = '{127, 127, 1, 0, 1, 0, 29};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 15};

    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset food_x", int'(food_x), 20);
    check("reset food_y", int'(food_y), 15);
    check("reset food_valid", int'(food_valid), 1);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    check("reset occ_req", int'(occ_req), 0);
    check("reset occ_xy", int'({occ_x, occ_y}), 0);
    check("reset grid_full", int'(grid_full), 0);

    // Directed draw table: empty board, immediate ack.
    for (int i = 0; i < 7; i++) begin
      clear_env();
      for (int k = 0; k < MAXC; k++) begin
        w = k / GAP;
        v = (w == 0) ? vecs[i].s0 : (w == 1) ? vecs[i].s1 : (w == 2) ? vecs[i].s2 : vecs[i].s3;
        seq_mem[k] = 7'(v);
      end
      exp_qx[0] = vecs[i].ex; exp_qy[0] = vecs[i].ey;
      run_txn((i == 0) ? 5 : -1, 400);
      check_txn($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].et, 1);
    end

    // First candidate (4,4) occupied, retry at (9,9) free; every ack 3 cycles late.
    clear_env();
    occ_map[4][4] = 1'b1;
    dly[0] = 3; dly[1] = 3;
    for (int k = 0; k < MAXC; k++) seq_mem[k] = (k < 18) ? 7'd4 : 7'd9;
    exp_qx[0] = 4; exp_qy[0] = 4; exp_qx[1] = 9; exp_qy[1] = 9;
    run_txn(9, 400);
    check_txn("hit_retry", 9, 9, 36, 2);

    // Randomized placements against the reference.
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < MAXC; k++) seq_mem[k] = 7'($urandom_range(0, 127));
      for (int x = 0; x < 64; x++)
        for (int y = 0; y < 32; y++) occ_map[x][y] = ($urandom_range(0, 9) < 4);
      for (int i = 0; i < MAXQ; i++) dly[i] = $urandom_range(0, 3);
      model_run(et, ex, ey, enq);
      run_txn((n % 3 == 0) ? $urandom_range(0, 13) : -1, MAXC);
      check_txn($sformatf("rand%0d", n), ex, ey, et, enq);
    end

`ifdef FOOD_FALLBACK_SCAN_EN
    // 16 hits at (39,29), scan wraps to (0,0) which is free.
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++) occ_map[x][y] = 1'b1;
    occ_map[0][0] = 1'b0;
    for (int i = 0; i < MAXQ; i++) dly[i] = 0;
    for (int k = 0; k < MAXC; k++) begin
      ph = k % 15;
      seq_mem[k] = (ph < 7) ? 7'd39 : (ph < 14) ? 7'd29 : 7'd0;
    end
    run_txn(-1, 400);
    check("scan done_cycle", obs_done, 242);
    check("scan food_x", obs_fx, 0);
    check("scan food_y", obs_fy, 0);
    check("scan done_pulses", obs_ndone, 1);
    $display("txn scan_wrap: food=(%0d,%0d) done@%0d", obs_fx, obs_fy, obs_done);
    occ_map[0][0] = 1'b1;
    run_txn(-1, 3000);
    check("full done_pulses", obs_ndone, 0);
    check("full grid_full", int'(grid_full), 1);
    check("full food_valid", int'(food_valid), 0);
    check("full busy", int'(busy), 0);
    $display("txn grid_full: grid_full=%0d food_valid=%0d", grid_full, food_valid);
`endif

    // Reset while a query is outstanding.
    place_req = 1'b1; rnd = 7'd12;
    tick();
    place_req = 1'b0;
    begin
      int waited;
      waited = 0;
      while (occ_req !== 1'b1 && waited < 40) begin tick(); waited++; end
      check("midq reached_query", int'(occ_req === 1'b1), 1);
    end
    #3 rst_n = 1'b0;
    #2;
    check("midq async occ_req", int'(occ_req), 0);
    tick();
    #5 rst_n = 1'b1;
    tick();
    check("midq food_x", int'(food_x), 20);
    check("midq food_y", int'(food_y), 15);
    check("midq food_valid", int'(food_valid), 1);
    check("midq occ_req", int'(occ_req), 0);
    check("midq busy", int'(busy), 0);
    check("midq occ_x", int'(occ_x), 0);
    $display("txn reset_mid_query: food=(%0d,%0d) valid=%0d", food_x, food_y, food_valid);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
